// File: rtl/dsp_inreg_pipe.sv
// Elastic operand register pipeline for the DSP48A1 A/B/C/D paths.
// DEPTH stages with a combinational ready chain, bubble collapse, flush and occupancy count.
module dsp_inreg_pipe #(
  parameter int WIDTH       = 18,
  parameter int DEPTH       = 1,
  parameter int ZERO_BUBBLE = 1,
  localparam int OCC_W      = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             CLR,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OCC_W-1:0] OCC
);

  // Handshake: a word moves across a port only at a rising CLK edge where both
  // its valid and ready are 1; valid never waits on ready, ready may depend on valid.

  if (DEPTH == 0) begin : g_bypass
    logic out_valid;

    assign out_valid = CE & IN_VALID & ~CLR & ~RST;
    assign OUT_VALID = out_valid;
    assign IN_READY  = CE & OUT_READY & ~CLR & ~RST;
    assign OUT_DATA  = (RST || (ZERO_BUBBLE != 0 && !out_valid)) ? '0 : IN_DATA;
    assign OCC       = '0;
  end else begin : g_pipe
    logic [WIDTH-1:0] d_q  [DEPTH];
    logic [WIDTH-1:0] d_d  [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [DEPTH-1:0] v_q, v_d, up_v, adv;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             rdy;
    logic             out_valid;

    // Ready ripples from the output back to stage 0: a stage may load when it is
    // empty or when the stage downstream of it is loading this edge.
    always_comb begin
      adv = '0;
      rdy = OUT_READY;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        rdy    = CE & (~v_q[i] | rdy);
        adv[i] = rdy;
      end
    end

    always_comb begin
      up_d[0] = IN_DATA;
      up_v[0] = IN_VALID;
      for (int i = 1; i < DEPTH; i++) begin
        up_d[i] = d_q[i-1];
        up_v[i] = v_q[i-1];
      end
    end

    always_comb begin
      d_d   = d_q;
      v_d   = v_q;
      occ_d = '0;
      if (CLR) begin
        for (int i = 0; i < DEPTH; i++) d_d[i] = '0;
        v_d = '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (adv[i]) begin
            d_d[i] = up_d[i];
            v_d[i] = up_v[i];
          end
        end
      end
      for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OCC_W'(v_d[i]);
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        v_q   <= '0;
        occ_q <= '0;
      end else begin
        d_q   <= d_d;
        v_q   <= v_d;
        occ_q <= occ_d;
      end
    end

    assign out_valid = CE & v_q[DEPTH-1] & ~CLR;
    assign OUT_VALID = out_valid;
    assign IN_READY  = adv[0] & ~CLR & ~RST;
    assign OUT_DATA  = (ZERO_BUBBLE != 0 && !out_valid) ? '0 : d_q[DEPTH-1];
    assign OCC       = occ_q;
  end

endmodule

// File: tb/tb_dsp_inreg_pipe.sv
// Bench for dsp_inreg_pipe: DEPTH=3 instance against a word-position model with a
// scoreboard monitor, plus DEPTH=2 and DEPTH=0 instances for directed cases.
module tb_dsp_inreg_pipe;
  localparam int W = 18;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst, ce, clr, iv, ordy;
  logic [W-1:0] id;

  logic         rdy_r, val_r, rdy_2, val_2, rdy_0, val_0;
  logic [W-1:0] dat_r, dat_2, dat_0;
  logic [1:0]   occ_r, occ_2;
  logic [0:0]   occ_0;

  typedef struct {
    logic [W-1:0] d;
    int           p;
  } item_t;

  item_t        mq[$];
  logic [W-1:0] exp_q[$];
  int           n_chk  = 0;
  int           n_pass = 0;

  dsp_inreg_pipe #(.WIDTH(W), .DEPTH(D), .ZERO_BUBBLE(1)) dut_r (
    .CLK(clk), .RST(rst), .CE(ce), .CLR(clr), .IN_DATA(id), .IN_VALID(iv),
    .IN_READY(rdy_r), .OUT_DATA(dat_r), .OUT_VALID(val_r), .OUT_READY(ordy), .OCC(occ_r));

  dsp_inreg_pipe #(.WIDTH(W), .DEPTH(2), .ZERO_BUBBLE(1)) dut_2 (
    .CLK(clk), .RST(rst), .CE(ce), .CLR(clr), .IN_DATA(id), .IN_VALID(iv),
    .IN_READY(rdy_2), .OUT_DATA(dat_2), .OUT_VALID(val_2), .OUT_READY(ordy), .OCC(occ_2));

  dsp_inreg_pipe #(.WIDTH(W), .DEPTH(0), .ZERO_BUBBLE(0)) dut_0 (
    .CLK(clk), .RST(rst), .CE(ce), .CLR(clr), .IN_DATA(id), .IN_VALID(iv),
    .IN_READY(rdy_0), .OUT_DATA(dat_0), .OUT_VALID(val_0), .OUT_READY(ordy), .OCC(occ_0));

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: each held word has a position 0..D-1; words slide toward the
  // output and pack up behind the word ahead; a new word enters at 0 if room remains.
  task automatic model_update();
    int lim;
    int np;
    if (clr) begin
      mq.delete();
      exp_q.delete();
    end else if (ce) begin
      if (mq.size() > 0 && mq[0].p == D - 1 && ordy) void'(mq.pop_front());
      lim = D;
      foreach (mq[i]) begin
        np       = (mq[i].p + 1 < lim - 1) ? mq[i].p + 1 : lim - 1;
        mq[i].p  = np;
        lim      = np;
      end
      if (iv && lim > 0) begin
        mq.push_back('{d: id, p: 0});
        exp_q.push_back(id);
      end
    end
  endtask

  task automatic auto_check();
    int sz;
    bit ev;
    sz = mq.size();
    ev = ce && !clr && sz > 0 && mq[0].p == D - 1;
    chk("r_in_ready", 32'(rdy_r), 32'(ce && !clr && (sz < D || ordy)));
    chk("r_out_valid", 32'(val_r), 32'(ev));
    chk("r_out_data", 32'(dat_r), ev ? 32'(mq[0].d) : 32'd0);
    chk("r_occ", 32'(occ_r), 32'(sz));
    chk("b_out_data", 32'(dat_0), 32'(id));
    chk("b_out_valid", 32'(val_0), 32'(ce && iv && !clr));
    chk("b_in_ready", 32'(rdy_0), 32'(ce && ordy && !clr));
    chk("b_occ", 32'(occ_0), 32'd0);
  endtask

  // driver tasks
  task automatic drive(input logic c, input logic cl, input logic v, input logic [W-1:0] d,
                       input logic r);
    ce = c; clr = cl; iv = v; id = d; ordy = r;
    #1;
    if (!rst) auto_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      tick();
    end
  endtask

  // scoreboard monitor: every output transfer must match the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && val_r && ordy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL mon_unexpected: got %0h, expected no output", dat_r);
        end else begin
          chk("mon_data", 32'(dat_r), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] bp [4];
    int           s;
    int           occ_frz;
    logic         c;

    bp[0] = 18'h3FFFF; bp[1] = 18'h12345; bp[2] = 18'h00ABC; bp[3] = 18'h00001;
    rst = 1'b1; ce = 1'b0; clr = 1'b0; iv = 1'b0; id = '0; ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r_occ", 32'(occ_r), 32'd0);
    chk("rst_r_out_valid", 32'(val_r), 32'd0);
    chk("rst_r_out_data", 32'(dat_r), 32'd0);
    chk("rst_r_in_ready", 32'(rdy_r), 32'd0);
    rst = 1'b0;

    // stream through DEPTH=2: each word shows up two cycles after it is offered
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b0, j < 5, W'(j + 1), 1'b1);
      chk("s2_out_valid", 32'(val_2), 32'(j >= 2 && j <= 6));
      chk("s2_out_data", 32'(dat_2), (j >= 2 && j <= 6) ? 32'(j - 1) : 32'd0);
      if (j < 5) chk("s2_in_ready", 32'(rdy_2), 32'd1);
      tick();
    end
    drain(4);

    // backpressure on DEPTH=3
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, bp[k], 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, bp[3], 1'b0);
    chk("bp_occ_full", 32'(occ_r), 32'd3);
    chk("bp_in_ready_full", 32'(rdy_r), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, bp[3], 1'b1);
    chk("bp_in_ready_drain", 32'(rdy_r), 32'd1);
    chk("bp_first_out", 32'(dat_r), 32'h3FFFF);
    tick();
    drain(5);

    // bubble collapse with the output stalled
    drive(1'b1, 1'b0, 1'b1, 18'h0A5A5, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);        tick();
    drive(1'b1, 1'b0, 1'b1, 18'h15A5A, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);        tick();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("bub_occ", 32'(occ_r), 32'd2);
    chk("bub_head", 32'(dat_r), 32'h0A5A5);
    tick();
    drain(5);

    // CE freeze mid-stream
    s = 0;
    occ_frz = 0;
    for (int k = 0; k < 10; k++) begin
      c = !(k >= 4 && k <= 6);
      if (k == 4) occ_frz = mq.size();
      drive(c, 1'b0, 1'b1, W'(18'h00100 + s), 1'b1);
      if (!c) begin
        chk("frz_out_valid", 32'(val_r), 32'd0);
        chk("frz_in_ready", 32'(rdy_r), 32'd0);
        chk("frz_occ", 32'(occ_r), 32'(occ_frz));
      end
      tick();
      if (c) s++;
    end
    drain(5);

    // flush while CE is low
    drive(1'b1, 1'b0, 1'b1, 18'h00777, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 18'h00888, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 18'h1DEAD, 1'b1);
    chk("clr_in_ready", 32'(rdy_r), 32'd0);
    chk("clr_out_valid", 32'(val_r), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("clr_occ", 32'(occ_r), 32'd0);
    chk("clr_occ_d2", 32'(occ_2), 32'd0);
    chk("clr_out_valid_after", 32'(val_r), 32'd0);
    tick();
    drain(4);

    // combinational bypass
    drive(1'b1, 1'b0, 1'b1, 18'h2AAAA, 1'b0);
    chk("dz_out_data", 32'(dat_0), 32'h2AAAA);
    chk("dz_out_valid", 32'(val_0), 32'd1);
    chk("dz_in_ready", 32'(rdy_0), 32'd0);
    tick();
    drain(5);

    // asynchronous reset with DEPTH=2 full
    drive(1'b1, 1'b0, 1'b1, 18'h00011, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 18'h00022, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_pre_occ2", 32'(occ_2), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_occ2", 32'(occ_2), 32'd0);
    chk("arst_out_valid2", 32'(val_2), 32'd0);
    chk("arst_out_data2", 32'(dat_2), 32'd0);
    chk("arst_in_ready2", 32'(rdy_2), 32'd0);
    chk("arst_occ_r", 32'(occ_r), 32'd0);
    mq.delete();
    exp_q.delete();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 18'h00033, 1'b1);
    tick();
    drain(5);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            W'($urandom), $urandom_range(0, 2) != 0);
      tick();
    end
    drain(6);
    chk("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
